// File: rtl/bp_me_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bp_me_pkg: shared types and helpers for the IO command arbiter       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bp_me_pkg;

   typedef enum logic [0:0] {
      e_io_arb_idle = 1'b0,
      e_io_arb_busy = 1'b1
   } bp_io_arb_state_e;

   function automatic int wrap_add(input int base, input int ofs, input int n);
      return (base + ofs) % n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_fifo_1r1w_small.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bsg_fifo_1r1w_small: small circular FIFO with occupancy count        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bsg_fifo_1r1w_small #(
   parameter int width_p = 1,
   parameter int els_p   = 4
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         v_i,
   output logic                         ready_o,
   input  logic [width_p-1:0]           data_i,
   output logic                         v_o,
   output logic [width_p-1:0]           data_o,
   input  logic                         yumi_i,
   output logic [$clog2(els_p+1)-1:0]   count_o
);

   localparam int c_ptr_w = $clog2(els_p);
   localparam int c_cnt_w = $clog2(els_p + 1);

   logic [width_p-1:0] r_mem [els_p];
   logic [c_ptr_w-1:0] r_wptr;
   logic [c_ptr_w-1:0] r_rptr;
   logic [c_cnt_w-1:0] r_count;
   logic               w_push;
   logic               w_pop;

   // Fullness comes from registered count only, so a same-cycle pop never frees a slot early.
   assign ready_o = (r_count != c_cnt_w'(els_p));
   assign v_o     = (r_count != '0);
   assign data_o  = r_mem[r_rptr];
   assign count_o = r_count;
   assign w_push  = v_i & ready_o;
   assign w_pop   = yumi_i & v_o;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wptr <= (r_wptr == c_ptr_w'(els_p - 1)) ? '0 : r_wptr + c_ptr_w'(1);
         if (w_pop)
            r_rptr <= (r_rptr == c_ptr_w'(els_p - 1)) ? '0 : r_rptr + c_ptr_w'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push)
         r_mem[r_wptr] <= data_i;
   end

endmodule
`default_nettype wire

// File: rtl/bp_io_cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bp_io_cmd_arbiter: round-robin IO command arbiter with message lock  |
// | and in-order response steering back to the issuing requester        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bp_io_cmd_arbiter
   import bp_me_pkg::*;
#(
   parameter int num_req_p     = 2,
   parameter int data_width_p  = 64,
   parameter int outstanding_p = 4
) (
   input  logic                                 clk_i,
   input  logic                                 reset_n_i,
   input  logic [num_req_p-1:0]                 req_v_i,
   input  logic [num_req_p*data_width_p-1:0]    req_data_i,
   input  logic [num_req_p-1:0]                 req_last_i,
   output logic [num_req_p-1:0]                 req_ready_o,
   output logic                                 cmd_v_o,
   output logic [data_width_p-1:0]              cmd_data_o,
   output logic                                 cmd_last_o,
   input  logic                                 cmd_ready_i,
   input  logic                                 resp_v_i,
   input  logic [data_width_p-1:0]              resp_data_i,
   output logic                                 resp_ready_o,
   output logic [num_req_p-1:0]                 resp_v_o,
   output logic [data_width_p-1:0]              resp_data_o,
   input  logic [num_req_p-1:0]                 resp_ready_i,
   output logic [$clog2(outstanding_p+1)-1:0]   outstanding_o,
   output logic                                 err_o
);

   localparam int c_sel_w = $clog2(num_req_p);

   bp_io_arb_state_e       r_state;
   logic [c_sel_w-1:0]     r_lock;
   logic [c_sel_w-1:0]     r_rr;
   logic                   r_err;
   logic [c_sel_w-1:0]     w_sel;
   logic [c_sel_w-1:0]     w_idx;
   logic [c_sel_w-1:0]     w_src;
   logic [c_sel_w-1:0]     w_head;
   logic                   w_found;
   logic                   w_fifo_ready;
   logic                   w_fifo_v;
   logic                   w_cmd_hs;
   logic                   w_push;
   logic                   w_pop;
   logic [data_width_p-1:0] w_req_data [num_req_p];

   for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
      assign w_req_data[g] = req_data_i[g*data_width_p +: data_width_p];
   end

   // Descending scan so the requester closest to the rr pointer is written last and wins.
   always_comb begin
      w_sel   = '0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int k = num_req_p - 1; k >= 0; k--) begin
         w_idx = c_sel_w'(wrap_add(int'(r_rr), k, num_req_p));
         if (req_v_i[w_idx]) begin
            w_sel   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   assign w_src = (r_state == e_io_arb_busy) ? r_lock : w_sel;

   always_comb begin
      cmd_v_o     = 1'b0;
      req_ready_o = '0;
      if (reset_n_i) begin
         if (r_state == e_io_arb_busy) begin
            cmd_v_o             = req_v_i[r_lock];
            req_ready_o[r_lock] = cmd_ready_i;
         end else if (w_fifo_ready && w_found) begin
            cmd_v_o            = 1'b1;
            req_ready_o[w_sel] = cmd_ready_i;
         end
      end
   end

   assign cmd_data_o = reset_n_i ? w_req_data[w_src] : '0;
   assign cmd_last_o = reset_n_i & req_last_i[w_src];
   assign w_cmd_hs   = cmd_v_o & cmd_ready_i;
   assign w_push     = w_cmd_hs & (r_state == e_io_arb_idle);

   always_comb begin
      resp_v_o         = '0;
      resp_v_o[w_head] = reset_n_i & resp_v_i & w_fifo_v;
      resp_ready_o     = reset_n_i & resp_ready_i[w_head] & w_fifo_v;
   end

   assign resp_data_o = reset_n_i ? resp_data_i : '0;
   assign w_pop       = resp_v_i & resp_ready_o;
   assign err_o       = r_err;

   bsg_fifo_1r1w_small #(
      .width_p (c_sel_w),
      .els_p   (outstanding_p)
   ) u_tag_fifo (
      .clk_i   (clk_i),
      .reset_i (~reset_n_i),
      .v_i     (w_push),
      .ready_o (w_fifo_ready),
      .data_i  (w_sel),
      .v_o     (w_fifo_v),
      .data_o  (w_head),
      .yumi_i  (w_pop),
      .count_o (outstanding_o)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_state <= e_io_arb_idle;
         r_lock  <= '0;
         r_rr    <= '0;
         r_err   <= 1'b0;
      end else begin
         if (resp_v_i && !w_fifo_v)
            r_err <= 1'b1;
         case (r_state)
            e_io_arb_idle: begin
               if (w_cmd_hs) begin
                  r_rr <= c_sel_w'(wrap_add(int'(w_sel), 1, num_req_p));
                  if (!cmd_last_o) begin
                     r_state <= e_io_arb_busy;
                     r_lock  <= w_sel;
                  end
               end
            end
            e_io_arb_busy: begin
               if (w_cmd_hs && cmd_last_o)
                  r_state <= e_io_arb_idle;
            end
            default: r_state <= e_io_arb_idle;
         endcase
      end
   end

   // Requesters must keep a stalled beat unchanged until it is accepted.
   for (genvar g = 0; g < num_req_p; g++) begin : g_hold
      a_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
         (req_v_i[g] && !req_ready_o[g]) |=> (req_v_i[g] && $stable(w_req_data[g])));
   end

endmodule
`default_nettype wire

// File: tb/tb_bp_io_cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bp_io_cmd_arbiter: directed and random checks of the IO arbiter   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_bp_io_cmd_arbiter;

   localparam int N   = 2;
   localparam int DW  = 64;
   localparam int OUT = 4;

   logic            clk_i = 1'b0;
   logic            reset_n_i;
   logic [N-1:0]    req_v_i;
   logic [N*DW-1:0] req_data_i;
   logic [N-1:0]    req_last_i;
   logic [N-1:0]    req_ready_o;
   logic            cmd_v_o;
   logic [DW-1:0]   cmd_data_o;
   logic            cmd_last_o;
   logic            cmd_ready_i;
   logic            resp_v_i;
   logic [DW-1:0]   resp_data_i;
   logic            resp_ready_o;
   logic [N-1:0]    resp_v_o;
   logic [DW-1:0]   resp_data_o;
   logic [N-1:0]    resp_ready_i;
   logic [2:0]      outstanding_o;
   logic            err_o;

   always #5 clk_i = ~clk_i;

   bp_io_cmd_arbiter #(
      .num_req_p     (N),
      .data_width_p  (DW),
      .outstanding_p (OUT)
   ) dut (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .req_v_i       (req_v_i),
      .req_data_i    (req_data_i),
      .req_last_i    (req_last_i),
      .req_ready_o   (req_ready_o),
      .cmd_v_o       (cmd_v_o),
      .cmd_data_o    (cmd_data_o),
      .cmd_last_o    (cmd_last_o),
      .cmd_ready_i   (cmd_ready_i),
      .resp_v_i      (resp_v_i),
      .resp_data_i   (resp_data_i),
      .resp_ready_o  (resp_ready_o),
      .resp_v_o      (resp_v_o),
      .resp_data_o   (resp_data_o),
      .resp_ready_i  (resp_ready_i),
      .outstanding_o (outstanding_o),
      .err_o         (err_o)
   );

   typedef struct packed {
      logic [63:0] d;
      logic        l;
   } beat_t;

   int          checks = 0;
   int          errors = 0;
   beat_t       q0[$];
   beat_t       q1[$];
   int          tq[$];
   bit          m_busy;
   int          m_lock;
   int          m_rr;
   bit          m_err;
   bit          resp_pend;
   logic [63:0] resp_d;
   logic [1:0]  hist_rdy[$];
   logic [63:0] o_data;
   logic [63:0] o_rdata;
   logic [1:0]  o_rv;
   logic        o_rrdy;
   logic [2:0]  o_out;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic add_msg(input int i, input int len, input logic [63:0] base);
      for (int b = 0; b < len; b++) begin
         beat_t bt;
         bt.d = base + 64'(b);
         bt.l = (b == len - 1);
         if (i == 0) q0.push_back(bt);
         else        q1.push_back(bt);
      end
   endtask

   task automatic drive();
      req_v_i    = {q1.size() != 0, q0.size() != 0};
      req_data_i = '0;
      req_last_i = '0;
      if (q0.size() != 0) begin
         req_data_i[63:0] = q0[0].d;
         req_last_i[0]    = q0[0].l;
      end
      if (q1.size() != 0) begin
         req_data_i[127:64] = q1[0].d;
         req_last_i[1]      = q1[0].l;
      end
      resp_v_i    = resp_pend;
      resp_data_i = resp_pend ? resp_d : '0;
   endtask

   task automatic model_clear();
      q0.delete();
      q1.delete();
      tq.delete();
      m_busy    = 0;
      m_lock    = 0;
      m_rr      = 0;
      m_err     = 0;
      resp_pend = 0;
   endtask

   // One clock: predict every output from the model, compare, then advance the model past the edge.
   task automatic step();
      int          src;
      bit          cv;
      bit          empty;
      bit          erdy;
      bit          pop;
      int          head;
      logic [1:0]  exp_rdy;
      logic [1:0]  exp_rv;
      beat_t       b;
      drive();
      #2;
      cv      = 0;
      src     = 0;
      exp_rdy = '0;
      if (m_busy) begin
         src = m_lock;
         cv  = (src == 0) ? (q0.size() != 0) : (q1.size() != 0);
         exp_rdy[src] = cmd_ready_i;
      end else if (tq.size() < OUT) begin
         for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = (m_rr + k) % N;
            if ((idx == 0) ? (q0.size() != 0) : (q1.size() != 0)) begin
               src = idx;
               cv  = 1;
            end
         end
         if (cv) exp_rdy[src] = cmd_ready_i;
      end
      chk("cmd_v", 64'(cmd_v_o), 64'(cv));
      chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
      if (cv) begin
         b = (src == 0) ? q0[0] : q1[0];
         chk("cmd_data", cmd_data_o, b.d);
         chk("cmd_last", 64'(cmd_last_o), 64'(b.l));
      end
      empty  = (tq.size() == 0);
      head   = empty ? 0 : tq[0];
      exp_rv = (resp_pend && !empty) ? 2'(1 << head) : 2'b00;
      erdy   = !empty && resp_ready_i[head];
      chk("resp_v", 64'(resp_v_o), 64'(exp_rv));
      chk("resp_ready", 64'(resp_ready_o), 64'(erdy));
      if (resp_pend) chk("resp_data", resp_data_o, resp_d);
      chk("outstanding", 64'(outstanding_o), 64'(tq.size()));
      chk("err", 64'(err_o), 64'(m_err));
      hist_rdy.push_back(req_ready_o);
      o_data  = cmd_data_o;
      o_rdata = resp_data_o;
      o_rv    = resp_v_o;
      o_rrdy  = resp_ready_o;
      o_out   = outstanding_o;
      pop     = resp_pend && erdy;
      @(posedge clk_i);
      #1;
      if (cv && cmd_ready_i) begin
         if (src == 0) b = q0.pop_front();
         else          b = q1.pop_front();
         if (!m_busy) begin
            tq.push_back(src);
            m_rr = (src + 1) % N;
            if (!b.l) begin
               m_busy = 1;
               m_lock = src;
            end
         end else if (b.l) begin
            m_busy = 0;
         end
      end
      if (pop) begin
         void'(tq.pop_front());
         resp_pend = 0;
      end else if (resp_pend && empty) begin
         m_err = 1;
      end
   endtask

   task automatic do_reset();
      reset_n_i = 1'b0;
      @(posedge clk_i);
      #1;
      model_clear();
      cmd_ready_i  = 1'b0;
      resp_ready_i = '0;
      drive();
      @(posedge clk_i);
      #1;
      chk("rst_cmd_v", 64'(cmd_v_o), 64'd0);
      chk("rst_req_ready", 64'(req_ready_o), 64'd0);
      chk("rst_resp_v", 64'(resp_v_o), 64'd0);
      chk("rst_resp_ready", 64'(resp_ready_o), 64'd0);
      chk("rst_outstanding", 64'(outstanding_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      reset_n_i = 1'b1;
      hist_rdy.delete();
   endtask

   initial begin
      logic [1:0] exp2 [6];
      reset_n_i = 1'b0;
      model_clear();
      cmd_ready_i  = 1'b0;
      resp_ready_i = '0;
      drive();

      // Single beat from req0 passes through in the same cycle
      do_reset();
      cmd_ready_i = 1'b1;
      add_msg(0, 1, 64'hA5);
      step();
      chk("t1_data", o_data, 64'hA5);
      chk("t1_out", 64'(outstanding_o), 64'd1);
      add_msg(0, 1, 64'h1);
      add_msg(1, 1, 64'h2);
      step();
      chk("t1_rr", 64'(hist_rdy[1]), 64'(2'b10));

      // Both requesters contend with single beats until the tag FIFO fills
      do_reset();
      cmd_ready_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         add_msg(0, 1, 64'(16'h200 + k));
         add_msg(1, 1, 64'(16'h280 + k));
      end
      for (int k = 0; k < 6; k++) step();
      exp2 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
      for (int k = 0; k < 6; k++) chk("t2_grant", 64'(hist_rdy[k]), 64'(exp2[k]));
      chk("t2_full", 64'(outstanding_o), 64'd4);

      // Multi-beat message from req1 holds the grant against req0
      do_reset();
      cmd_ready_i = 1'b1;
      add_msg(0, 1, 64'h30);
      step();
      add_msg(1, 3, 64'h300);
      add_msg(0, 1, 64'h31);
      for (int k = 0; k < 4; k++) step();
      chk("t3_b1", 64'(hist_rdy[1]), 64'(2'b10));
      chk("t3_b3", 64'(hist_rdy[3]), 64'(2'b10));
      chk("t3_req0", 64'(hist_rdy[4]), 64'(2'b01));

      // Same with downstream stalling mid-message
      do_reset();
      cmd_ready_i = 1'b1;
      add_msg(0, 1, 64'h40);
      step();
      add_msg(1, 3, 64'h400);
      add_msg(0, 1, 64'h41);
      step();
      cmd_ready_i = 1'b0;
      step();
      chk("t3_hold_data", o_data, 64'h401);
      step();
      cmd_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) step();
      chk("t3_stall_lock", 64'(hist_rdy[5]), 64'(2'b10));
      chk("t3_stall_rel", 64'(hist_rdy[6]), 64'(2'b01));

      // Responses steer back in issue order
      do_reset();
      cmd_ready_i = 1'b1;
      add_msg(1, 1, 64'h50);
      step();
      add_msg(0, 1, 64'h51);
      step();
      resp_pend    = 1;
      resp_d       = 64'h11;
      resp_ready_i = 2'b01;
      step();
      chk("t4_stall_v", 64'(o_rv), 64'(2'b10));
      chk("t4_stall_rdy", 64'(o_rrdy), 64'd0);
      resp_ready_i = 2'b11;
      step();
      chk("t4_r1_v", 64'(o_rv), 64'(2'b10));
      chk("t4_r1_rdy", 64'(o_rrdy), 64'd1);
      resp_pend = 1;
      resp_d    = 64'h22;
      step();
      chk("t4_r0_v", 64'(o_rv), 64'(2'b01));
      chk("t4_r0_data", o_rdata, 64'h22);

      // Full FIFO: same-cycle pop does not admit a new push
      do_reset();
      cmd_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         add_msg(0, 1, 64'(16'h500 + k));
         step();
      end
      add_msg(0, 1, 64'h555);
      resp_pend    = 1;
      resp_d       = 64'h5;
      resp_ready_i = 2'b11;
      step();
      chk("t5_blocked", 64'(hist_rdy[4]), 64'd0);
      chk("t5_out4", 64'(o_out), 64'd4);
      step();
      chk("t5_accept", 64'(hist_rdy[5]), 64'(2'b01));
      chk("t5_out3", 64'(o_out), 64'd3);
      chk("t5_out4b", 64'(outstanding_o), 64'd4);

      // Stray response sets sticky error; reset mid-message clears everything
      do_reset();
      resp_pend = 1;
      resp_d    = 64'h66;
      step();
      chk("t6_rdy", 64'(o_rrdy), 64'd0);
      chk("t6_err", 64'(err_o), 64'd1);
      resp_pend = 0;
      step();
      cmd_ready_i = 1'b1;
      add_msg(1, 3, 64'h600);
      step();
      reset_n_i = 1'b0;
      drive();
      #2;
      chk("t6_rst_cmd_v", 64'(cmd_v_o), 64'd0);
      @(posedge clk_i);
      #1;
      chk("t6_rst_err", 64'(err_o), 64'd0);
      chk("t6_rst_out", 64'(outstanding_o), 64'd0);
      model_clear();
      drive();
      @(posedge clk_i);
      #1;
      reset_n_i = 1'b1;
      hist_rdy.delete();
      add_msg(0, 1, 64'h77);
      step();
      chk("t6_idle", 64'(hist_rdy[0]), 64'(2'b01));

      // Random traffic against the model
      do_reset();
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(0, 3) == 0 && q0.size() < 6)
            add_msg(0, int'($urandom_range(1, 3)), {$urandom, $urandom});
         if ($urandom_range(0, 3) == 0 && q1.size() < 6)
            add_msg(1, int'($urandom_range(1, 3)), {$urandom, $urandom});
         cmd_ready_i = ($urandom_range(0, 3) != 0);
         if (!resp_pend && tq.size() != 0 && $urandom_range(0, 1) == 1) begin
            resp_pend = 1;
            resp_d    = {$urandom, $urandom};
         end
         resp_ready_i = 2'($urandom_range(0, 3));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
